// File: rtl/bus_cycle_initiator_if.sv
// rtl/bus_cycle_initiator_if.sv - request/response handshake and bus control signals of the cycle initiator
interface bus_cycle_initiator_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_io;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] address;
    logic                  ale;
    logic                  rd_n;
    logic                  wr_n;
    logic                  iom;
    logic                  ready;

    modport master (
        input  req_valid, req_write, req_io, req_addr, req_wdata, ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, address, ale, rd_n, wr_n, iom
    );

    modport slave (
        output req_valid, req_write, req_io, req_addr, req_wdata, ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, address, ale, rd_n, wr_n, iom
    );
endinterface

// File: rtl/bus_cycle_initiator.sv
// rtl/bus_cycle_initiator.sv - T1/T2/T3/TW/T4 bus cycle sequencer with wait-state timeout
module bus_cycle_initiator #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    bus_cycle_initiator_if.master bus,
    inout  wire  [DATA_WIDTH-1:0] io_data
);
    localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W:0]        LIMIT   = (CNT_W + 1)'(WAIT_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] IO_MASK = ADDR_WIDTH'(65535);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_abort;
    logic                  w_capture;
    logic                  w_strobe_next;
    logic [CNT_W:0]        w_cnt_inc;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_req_ready;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_address;
    logic                  r_iom;
    logic                  r_ale;
    logic                  r_rd_n;
    logic                  r_wr_n;
    logic                  r_data_oe;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    assign w_cnt_inc = {1'b0, r_wait_cnt} + (CNT_W + 1)'(1);

    always_comb begin
        w_next    = r_state;
        w_abort   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: if (r_req_ready && bus.req_valid) w_next = S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3: begin
                if (bus.ready) begin
                    w_next    = S_T4;
                    w_capture = 1'b1;
                end else if (WAIT_LIMIT == 0) begin
                    w_next  = S_T4;
                    w_abort = 1'b1;
                end else begin
                    w_next = S_TW;
                end
            end
            S_TW: begin
                if (bus.ready) begin
                    w_next    = S_T4;
                    w_capture = 1'b1;
                end else if (w_cnt_inc >= LIMIT) begin
                    w_next  = S_T4;
                    w_abort = 1'b1;
                end
            end
            S_T4:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_strobe_next = (w_next == S_T2) || (w_next == S_T3) || (w_next == S_TW);
    end

    // Bus outputs are decoded from the next state so every pin comes straight from a flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_req_ready <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_address   <= '0;
            r_iom       <= 1'b0;
            r_ale       <= 1'b0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == S_IDLE);
            r_ale       <= (w_next == S_T1);
            r_rd_n      <= !(w_strobe_next && !r_write);
            r_wr_n      <= !(w_strobe_next && r_write);
            r_data_oe   <= w_strobe_next && r_write;
            r_rsp_valid <= (w_next == S_T4);
            r_rsp_err   <= w_abort;
            if (r_state == S_IDLE && w_next == S_T1) begin
                r_write   <= bus.req_write;
                r_wdata   <= bus.req_wdata;
                r_iom     <= bus.req_io;
                r_address <= bus.req_io ? (bus.req_addr & IO_MASK) : bus.req_addr;
            end
            if (r_state == S_T2) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_TW) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_capture && !r_write) begin
                r_rsp_rdata <= io_data;
            end else if (w_abort && !r_write) begin
                r_rsp_rdata <= '1;
            end
        end
    end

    assign io_data       = r_data_oe ? r_wdata : {DATA_WIDTH{1'bz}};
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.address   = r_address;
    assign bus.ale       = r_ale;
    assign bus.rd_n      = r_rd_n;
    assign bus.wr_n      = r_wr_n;
    assign bus.iom       = r_iom;
endmodule

// File: tb/tb_bus_cycle_initiator.sv
// tb/tb_bus_cycle_initiator.sv - scoreboard bench for bus_cycle_initiator with a wait-state target model
module tb_bus_cycle_initiator;
    localparam int AW = 20;
    localparam int DW = 8;
    localparam int WL = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_cycle_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if();
    wire  [DW-1:0] data_bus;
    logic          tb_drv  = 1'b0;
    logic [DW-1:0] tb_data = '0;
    assign data_bus = tb_drv ? tb_data : {DW{1'bz}};

    bus_cycle_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus_if),
        .io_data (data_bus)
    );

    typedef struct {
        logic          write;
        logic          io;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            hs;
        int            lat;
    } exp_t;

    typedef struct {
        int            waits;
        logic [DW-1:0] rdata;
    } tgt_t;

    exp_t sb_q[$];
    tgt_t tgt_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: waits = READY-low samples the target will give from T3 on.
    task automatic issue(input logic w, input logic io, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                         input int waits, input bit hold, output int hs);
        exp_t e;
        tgt_t t;
        bit   done;
        done = 0;
        hs   = -1;
        bus_if.req_write = w;
        bus_if.req_io    = io;
        bus_if.req_addr  = a;
        bus_if.req_wdata = wd;
        bus_if.req_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus_if.req_ready) begin
                e.write = w;
                e.io    = io;
                e.addr  = io ? (a % 20'h10000) : a;
                e.wdata = wd;
                e.err   = (waits > WL);
                e.rdata = e.err ? 8'hFF : rd;
                e.hs    = cyc;
                e.lat   = 4 + (e.err ? WL : waits);
                sb_q.push_back(e);
                t.waits = waits;
                t.rdata = rd;
                tgt_q.push_back(t);
                hs   = cyc;
                done = 1;
            end
        end
        if (!done) check("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) bus_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Target: holds READY low for the requested number of samples, returns read data on RD low.
    initial begin
        int   idx;
        tgt_t cur;
        idx = -1;
        cur.waits = 0;
        cur.rdata = '0;
        bus_if.ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                idx          = -1;
                tb_drv       = 1'b0;
                bus_if.ready = 1'b1;
            end else begin
                if (!bus_if.rd_n || !bus_if.wr_n) begin
                    if (idx < 0) begin
                        idx = 0;
                        if (tgt_q.size() != 0) cur = tgt_q.pop_front();
                    end else begin
                        idx++;
                    end
                end else begin
                    idx = -1;
                end
                if (idx >= 1) bus_if.ready = (idx > cur.waits);
                else          bus_if.ready = 1'($urandom_range(0, 1));
                tb_drv  = !bus_if.rd_n;
                tb_data = cur.rdata;
            end
        end
    end

    // Monitor: bus protocol checks and response scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("data_oe", dut.r_data_oe, !bus_if.wr_n);
            if (!bus_if.rd_n || !bus_if.wr_n) begin
                check("strobe_exclusive", !bus_if.rd_n && !bus_if.wr_n, 0);
                if (sb_q.size() == 0) check("strobe_unexpected", 1, 0);
            end
            if (bus_if.ale) begin
                if (sb_q.size() == 0) begin
                    check("ale_unexpected", 1, 0);
                end else begin
                    check("t1_cycle", cyc, sb_q[0].hs + 1);
                    check("t1_address", bus_if.address, sb_q[0].addr);
                    check("t1_iom", bus_if.iom, sb_q[0].io);
                    check("t1_strobes", {bus_if.rd_n, bus_if.wr_n}, 2'b11);
                end
            end
            if (!bus_if.wr_n && sb_q.size() != 0) begin
                check("wr_direction", sb_q[0].write, 1);
                check("wr_data", data_bus, sb_q[0].wdata);
            end
            if (!bus_if.rd_n && sb_q.size() != 0) check("rd_direction", sb_q[0].write, 0);
            if (bus_if.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_cycle", cyc, e.hs + e.lat);
                    check("rsp_err", bus_if.rsp_err, e.err);
                    if (!e.write) check("rsp_rdata", bus_if.rsp_rdata, e.rdata);
                    check("t4_address", bus_if.address, e.addr);
                    check("t4_iom", bus_if.iom, e.io);
                    check("t4_strobes", {bus_if.rd_n, bus_if.wr_n, bus_if.ale}, 3'b110);
                end
            end
        end
    end

    initial begin
        int h1, h2, h3, h;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_io    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_req_ready", bus_if.req_ready, 0);
        check("rst_ale", bus_if.ale, 0);
        check("rst_rd_n", bus_if.rd_n, 1);
        check("rst_wr_n", bus_if.wr_n, 1);
        check("rst_iom", bus_if.iom, 0);
        check("rst_address", bus_if.address, 0);
        check("rst_rsp_valid", bus_if.rsp_valid, 0);
        check("rst_rsp_err", bus_if.rsp_err, 0);
        check("rst_rsp_rdata", bus_if.rsp_rdata, 0);
        check("rst_data_oe", dut.r_data_oe, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check("ready_before_edge", bus_if.req_ready, 0);
        @(negedge clk);
        check("ready_after_release", bus_if.req_ready, 1);
        @(posedge clk);
        #1;

        issue(1'b0, 1'b0, 20'h12345, 8'h00, 8'hA5, 0, 1'b0, h); drain();
        issue(1'b1, 1'b1, 20'hF0060, 8'h3C, 8'h00, 0, 1'b0, h); drain();
        issue(1'b0, 1'b0, 20'hABCDE, 8'h00, 8'h5E, 3, 1'b0, h); drain();
        issue(1'b0, 1'b1, 20'h01234, 8'h00, 8'h77, 40, 1'b0, h); drain();
        issue(1'b0, 1'b0, 20'h00FFF, 8'h00, 8'h81, 0, 1'b0, h); drain();
        issue(1'b1, 1'b0, 20'h7A5A5, 8'h96, 8'h00, WL, 1'b0, h); drain();
        issue(1'b0, 1'b0, 20'h8001F, 8'h00, 8'h3D, WL, 1'b0, h); drain();
        issue(1'b0, 1'b1, 20'hC4321, 8'h00, 8'h42, WL + 1, 1'b0, h); drain();

        issue(1'b1, 1'b0, 20'h10000, 8'h11, 8'h00, 0, 1'b1, h1);
        issue(1'b1, 1'b1, 20'h2ABCD, 8'h22, 8'h00, 0, 1'b1, h2);
        issue(1'b1, 1'b0, 20'h30003, 8'h33, 8'h00, 0, 1'b0, h3);
        check("b2b_period_1", h2 - h1, 5);
        check("b2b_period_2", h3 - h2, 5);
        drain();

        for (int n = 0; n < 40; n++) begin
            logic          w, io, hold;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, rd;
            int            waits;
            w     = 1'($urandom_range(0, 1));
            io    = 1'($urandom_range(0, 1));
            hold  = 1'($urandom_range(0, 1));
            a     = AW'($urandom);
            wd    = DW'($urandom);
            rd    = DW'($urandom);
            waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(WL - 1, WL + 3))
                                                : int'($urandom_range(0, 4));
            issue(w, io, a, wd, rd, waits, hold, h);
            if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        bus_if.req_valid = 1'b0;
        drain();

        issue(1'b1, 1'b0, 20'h55555, 8'hC3, 8'h00, 10, 1'b0, h);
        repeat (4) @(posedge clk);
        #2 check("pre_reset_wr_low", bus_if.wr_n, 0);
        #1 rst = 1'b1;
        #1;
        check("midrst_wr_n", bus_if.wr_n, 1);
        check("midrst_rd_n", bus_if.rd_n, 1);
        check("midrst_ale", bus_if.ale, 0);
        check("midrst_data_oe", dut.r_data_oe, 0);
        check("midrst_rsp_valid", bus_if.rsp_valid, 0);
        check("midrst_req_ready", bus_if.req_ready, 0);
        sb_q.delete();
        tgt_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rel_ready_before_edge", bus_if.req_ready, 0);
        @(negedge clk);
        check("rel_ready_after_edge", bus_if.req_ready, 1);
        @(posedge clk);
        #1;
        issue(1'b0, 1'b0, 20'h0BEEF, 8'h00, 8'hE7, 2, 1'b0, h); drain();
        repeat (6) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
